// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one add/sub datapath among N_REQ requesters,
// sequencing the datapath handshake and aborting transactions the datapath never answers.
module addsub_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_op,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_res,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [7:0]                 timeout_cnt,
    output logic                       dp_ready,
    output logic                       dp_add_sub,
    output logic [WIDTH-1:0]           dp_a,
    output logic [WIDTH-1:0]           dp_b,
    input  logic [WIDTH-1:0]           dp_res,
    input  logic                       dp_valid
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int TM_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [TM_W-1:0]   timer_q, timer_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              rst_hold_q;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              accept;
    logic [N_REQ-1:0]  grant_vec;

    // First requester above the pointer wins; the pointer itself has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // No grant in the reset cycle nor the one right after it.
    assign accept = (state_q == IDLE) && gnt_found && !rst_hold_q && !reset;

    always_comb begin
        grant_vec = '0;
        if (accept) begin
            grant_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        err_d    = err_q;
        timer_d  = timer_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    ptr_d   = gnt_idx;
                    id_d    = gnt_idx;
                    op_d    = req_op[gnt_idx];
                    a_d     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                if (dp_valid) begin
                    res_d    = dp_res;
                    err_d    = 1'b0;
                    rsp_id_d = id_q;
                    state_d  = RESP;
                end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
                    res_d    = '0;
                    err_d    = 1'b1;
                    rsp_id_d = id_q;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            rsp_id_q   <= '0;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            tcnt_q     <= '0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            tcnt_q     <= tcnt_d;
            rst_hold_q <= 1'b0;
        end
    end

    // Every output reads zero while reset is asserted, even mid-transaction.
    assign req_ready   = grant_vec;
    assign busy        = !reset && (state_q != IDLE);
    assign dp_ready    = !reset && (state_q == ISSUE);
    assign rsp_valid   = !reset && (state_q == RESP);
    assign rsp_id      = reset ? '0 : rsp_id_q;
    assign rsp_res     = reset ? '0 : res_q;
    assign rsp_err     = !reset && err_q;
    assign timeout_cnt = reset ? 8'd0 : tcnt_q;
    assign dp_add_sub  = !reset && op_q;
    assign dp_a        = reset ? '0 : a_q;
    assign dp_b        = reset ? '0 : b_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: datapath stub plus a transaction-level reference model,
// directed scenarios followed by randomized request traffic.
module tb_addsub_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_op, req_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic             rsp_valid, rsp_err, busy, dp_ready, dp_add_sub, dp_valid;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_res, dp_a, dp_b, dp_res;
    logic [7:0]       timeout_cnt;

    addsub_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .busy(busy), .timeout_cnt(timeout_cnt),
        .dp_ready(dp_ready), .dp_add_sub(dp_add_sub), .dp_a(dp_a), .dp_b(dp_b),
        .dp_res(dp_res), .dp_valid(dp_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // next-cycle stimulus, applied at the falling edge
    logic         nx_reset;
    logic [N-1:0] nx_valid, nx_op;
    logic [W-1:0] nx_a [N];
    logic [W-1:0] nx_b [N];
    bit           hold_all, dead, inject;
    logic [W-1:0] inject_res;

    // datapath stub
    int           stub_at = -1;
    logic [W-1:0] stub_res;

    // reference model
    int           cyc = 0;
    int           free_at = 0;
    int           g_cyc, r_cyc, g_id, m_ptr, m_tcnt;
    bit           m_busy, g_dead, m_op;
    logic [W-1:0] m_a, m_b, h_res;
    int           h_id;
    bit           h_err;

    int           gnt_q[$];
    int           gnt_cyc_q[$];
    int           rsp_q[$];
    logic [W-1:0] last_res;
    logic         last_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Winner is the valid requester at the smallest circular distance past the pointer.
    function automatic int pick_winner(input logic [N-1:0] v, input int p);
        int best, bd, d;
        best = -1;
        bd   = N + 1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - p - 1 + 2 * N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_check();
        logic [N-1:0] e_ready;
        bit           e_rv, e_busy, e_dpr;
        int           w;
        e_ready = '0;
        if (reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dp_ready", dp_ready, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_res", rsp_res, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_tcnt", timeout_cnt, 0);
            chk("rst_dp_a", dp_a, 0);
            chk("rst_dp_b", dp_b, 0);
            chk("rst_dp_add_sub", dp_add_sub, 0);
            m_busy  = 0;
            m_ptr   = N - 1;
            m_a     = '0;
            m_b     = '0;
            m_op    = 0;
            h_id    = 0;
            h_res   = '0;
            h_err   = 0;
            m_tcnt  = 0;
            free_at = cyc + 2;
            return;
        end
        e_rv = m_busy && (cyc == r_cyc);
        if (e_rv) begin
            h_id  = g_id;
            h_err = g_dead;
            h_res = g_dead ? W'(0) : (m_op ? W'(m_a + m_b) : W'(m_a - m_b));
            if (g_dead && m_tcnt < 255) m_tcnt++;
        end
        e_busy = m_busy && (cyc > g_cyc) && (cyc <= r_cyc);
        e_dpr  = m_busy && (cyc == g_cyc + 1);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("busy", busy, e_busy);
        chk("dp_ready", dp_ready, e_dpr);
        chk("rsp_id", rsp_id, h_id);
        chk("rsp_res", rsp_res, h_res);
        chk("rsp_err", rsp_err, h_err);
        chk("timeout_cnt", timeout_cnt, m_tcnt);
        chk("dp_a", dp_a, m_a);
        chk("dp_b", dp_b, m_b);
        chk("dp_add_sub", dp_add_sub, m_op);
        if (m_busy && cyc >= r_cyc) m_busy = 0;
        w = -1;
        if (cyc >= free_at && req_valid != '0) w = pick_winner(req_valid, m_ptr);
        if (w >= 0) begin
            e_ready[w] = 1'b1;
            m_ptr   = w;
            g_id    = w;
            g_cyc   = cyc;
            g_dead  = dead;
            r_cyc   = cyc + (dead ? TO + 2 : 4);
            free_at = r_cyc + 1;
            m_busy  = 1;
            m_op    = req_op[w];
            m_a     = req_a[w*W +: W];
            m_b     = req_b[w*W +: W];
        end
        chk("req_ready", req_ready, e_ready);
    endtask

    task automatic step();
        @(negedge clk);
        reset     = nx_reset;
        req_valid = nx_valid;
        req_op    = nx_op;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = nx_a[i];
            req_b[i*W +: W] = nx_b[i];
        end
        dp_valid = (cyc == stub_at) || inject;
        dp_res   = inject ? inject_res : ((cyc == stub_at) ? stub_res : W'($urandom));
        #1;
        model_check();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                gnt_q.push_back(i);
                gnt_cyc_q.push_back(cyc);
                if (!hold_all) nx_valid[i] = 1'b0;
            end
        end
        if (rsp_valid) begin
            rsp_q.push_back(int'(rsp_id));
            last_res = rsp_res;
            last_err = rsp_err;
        end
        if (dp_ready && !dead) begin
            stub_at  = cyc + 2;
            stub_res = dp_add_sub ? W'(dp_a + dp_b) : W'(dp_a - dp_b);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(input int i, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        nx_valid[i] = 1'b1;
        nx_op[i]    = op;
        nx_a[i]     = a;
        nx_b[i]     = b;
    endtask

    initial begin
        int n0;
        reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        dp_valid = 1'b0; dp_res = '0;
        nx_reset = 1'b1; nx_valid = '0; nx_op = '0;
        hold_all = 0; dead = 0; inject = 0; inject_res = '0;
        for (int i = 0; i < N; i++) begin nx_a[i] = '0; nx_b[i] = '0; end

        run(2);
        nx_reset = 1'b0;
        run(3);

        // single add 3+4
        set_req(0, 1, 4'd3, 4'd4);
        run(7);
        chk("add_id", rsp_q.size() > 0 ? rsp_q[$] : -1, 0);
        chk("add_res", last_res, 7);
        chk("add_err", last_err, 0);

        // subtraction wrap 2-5 and addition wrap 15+1
        set_req(2, 0, 4'd2, 4'd5);
        run(7);
        chk("sub_id", rsp_q.size() > 0 ? rsp_q[$] : -1, 2);
        chk("sub_res", last_res, 4'hD);
        set_req(1, 1, 4'd15, 4'd1);
        run(7);
        chk("wrap_id", rsp_q.size() > 0 ? rsp_q[$] : -1, 1);
        chk("wrap_res", last_res, 0);

        // round-robin with every requester held valid, starting from reset priority
        gnt_q.delete(); gnt_cyc_q.delete(); rsp_q.delete();
        for (int i = 0; i < N; i++) set_req(i, i[0], W'(i + 5), W'(i));
        hold_all = 1;
        nx_reset = 1'b1;
        step();
        nx_reset = 1'b0;
        run(24);
        hold_all = 0;
        nx_valid = '0;
        run(6);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_gnt%0d", i), i < gnt_q.size() ? gnt_q[i] : -1, i % N);
        for (int i = 1; i < 5; i++)
            chk($sformatf("rr_gap%0d", i),
                i < gnt_cyc_q.size() ? gnt_cyc_q[i] - gnt_cyc_q[i-1] : -1, 5);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_rsp%0d", i), i < rsp_q.size() ? rsp_q[i] : -1, i);

        // pointer skip: pointer at 1, then 1001, then pointer at 0 with 0011
        set_req(1, 1, 4'd1, 4'd1);
        run(6);
        gnt_q.delete();
        set_req(0, 0, 4'd9, 4'd3);
        set_req(3, 1, 4'd7, 4'd8);
        run(12);
        chk("skip_gnt0", gnt_q.size() > 0 ? gnt_q[0] : -1, 3);
        chk("skip_gnt1", gnt_q.size() > 1 ? gnt_q[1] : -1, 0);
        gnt_q.delete();
        set_req(0, 1, 4'd4, 4'd4);
        set_req(1, 0, 4'd6, 4'd1);
        run(12);
        chk("skip_gnt2", gnt_q.size() > 0 ? gnt_q[0] : -1, 1);
        chk("skip_gnt3", gnt_q.size() > 1 ? gnt_q[1] : -1, 0);

        // watchdog abort with a silent datapath, then a stray dp_valid while idle
        dead = 1;
        set_req(0, 1, 4'd3, 4'd4);
        gnt_cyc_q.delete();
        n0 = rsp_q.size();
        run(TO + 4);
        chk("to_rsp_count", rsp_q.size() - n0, 1);
        chk("to_err", last_err, 1);
        chk("to_res", last_res, 0);
        chk("to_tcnt", timeout_cnt, 1);
        dead = 0;
        n0 = rsp_q.size();
        inject = 1; inject_res = 4'hA;
        step();
        inject = 0;
        run(3);
        chk("late_dv_ignored", rsp_q.size(), n0);

        // reset during WAIT drops the transaction; requester 0 wins afterwards
        set_req(2, 1, 4'd5, 4'd5);
        run(3);
        n0 = rsp_q.size();
        gnt_q.delete();
        for (int i = 0; i < N; i++) set_req(i, 1, W'(i), 4'd1);
        nx_reset = 1'b1;
        step();
        nx_reset = 1'b0;
        step();
        chk("rst_no_rsp", rsp_q.size(), n0);
        run(25);
        chk("rst_first_gnt", gnt_q.size() > 0 ? gnt_q[0] : -1, 0);

        // randomized traffic
        nx_valid = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!nx_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom), W'($urandom), W'($urandom));
                end else if ($urandom_range(0, 9) == 0) begin
                    nx_valid[i] = 1'b0;
                end
            end
            if (!m_busy) dead = ($urandom_range(0, 5) == 0);
            nx_reset = ($urandom_range(0, 99) == 0);
            inject   = !m_busy && ($urandom_range(0, 19) == 0);
            inject_res = W'($urandom);
            step();
        end
        nx_reset = 1'b0; inject = 0; nx_valid = '0; dead = 0;
        run(TO + 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
